// File: rtl/gpu_dma_pkg.sv
// Shared types and constants for the OBM DMA controller.
// Provides the DMA state enum, OBM size, IRQ clear offset and a vblank helper.
package gpu_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } dma_state_e;

    localparam int OBM_BYTES = 256;

    localparam logic [11:0] DMA_IRQ_CLR_OFFSET = 12'h100;

    // Lines at or beyond the visible count belong to vertical blank.
    function automatic logic in_vblank(
        input logic [8:0] y,
        input logic [8:0] visible
    );
        return y >= visible;
    endfunction

endpackage

// File: rtl/vram_write_mux.sv
// CPU/DMA select for the foreground VRAM write port, with CPU stall generation.
// Ports: dma_busy/dma_we/dma_* (DMA side), cpu_* (CPU side), swallow, vram_* out, cpu_stall.
module vram_write_mux
    import gpu_dma_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 12
) (
    input  logic                       dma_busy,
    input  logic                       dma_we,
    input  logic [VRAM_ADDR_WIDTH-1:0] dma_address,
    input  logic [7:0]                 dma_data,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_vram_address,
    input  logic [7:0]                 cpu_data,
    input  logic                       cpu_write_enable,
    input  logic                       cpu_select_obm,
    input  logic                       swallow,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                 vram_data,
    output logic                       vram_write_enable,
    output logic                       vram_select_obm,
    output logic                       cpu_stall
);

    always_comb begin
        vram_address      = cpu_vram_address;
        vram_data         = cpu_data;
        vram_write_enable = cpu_write_enable;
        vram_select_obm   = cpu_select_obm;
        cpu_stall         = 1'b0;
        if (dma_we) begin
            // DMA owns the port; any CPU write this cycle must retry.
            vram_address      = dma_address;
            vram_data         = dma_data;
            vram_write_enable = 1'b1;
            vram_select_obm   = 1'b1;
            cpu_stall         = cpu_write_enable;
        end else if (swallow) begin
            vram_write_enable = 1'b0;
        end else if (dma_busy && cpu_select_obm && cpu_write_enable) begin
            // OBM is locked for the whole transfer to keep it tear-free.
            vram_write_enable = 1'b0;
            cpu_stall         = 1'b1;
        end
    end

endmodule

// File: rtl/obm_dma_controller.sv
// Copies a 256-byte object table from a work-RAM page into OBM during vblank,
// arbitrating the foreground VRAM write port between the DMA and the CPU.
// Ports: gpu_clk, rst (async active-low), start/src_page/next_y control,
// busy/done status, ram_addr/ram_rd_en/ram_rdata work-RAM read port,
// cpu_* CPU-side VRAM bus, vram_* foreground write port, cpu_stall, irq.
// Optional: define OBM_DMA_IRQ_EN for a sticky done interrupt cleared by
// a CPU write to OBM_BASE+0x100; otherwise irq is tied low.
module obm_dma_controller
    import gpu_dma_pkg::*;
#(
    parameter int                         NUM_OBJECTS     = 64,
    parameter int                         VISIBLE_LINES   = 240,
    parameter int                         RAM_ADDR_WIDTH  = 16,
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE        = 12'h800
) (
    input  logic                       gpu_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 src_page,
    input  logic [8:0]                 next_y,
    output logic                       busy,
    output logic                       done,
    output logic [RAM_ADDR_WIDTH-1:0]  ram_addr,
    output logic                       ram_rd_en,
    input  logic [7:0]                 ram_rdata,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_vram_address,
    input  logic [7:0]                 cpu_data,
    input  logic                       cpu_write_enable,
    input  logic                       cpu_select_obm,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                 vram_data,
    output logic                       vram_write_enable,
    output logic                       vram_select_obm,
    output logic                       cpu_stall,
    output logic                       irq
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ARM   = ARM;
    localparam logic [1:0] ST_XFER  = XFER;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    localparam logic [7:0] LAST_IDX = 8'(4 * NUM_OBJECTS - 1);

    logic [1:0] state_q;
    logic [7:0] page_q;
    logic [7:0] n_q;
    logic [7:0] n_d_q;
    logic       rd_valid_q;
    logic       done_q;
    logic       vblank;
    logic       dma_busy;
    logic       swallow;
    logic [VRAM_ADDR_WIDTH-1:0] dma_address;

    assign vblank    = in_vblank(next_y, 9'(VISIBLE_LINES));
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign dma_busy  = (state_q == ST_XFER) || (state_q == ST_DRAIN);
    assign ram_rd_en = (state_q == ST_XFER) && vblank;
    assign ram_addr  = RAM_ADDR_WIDTH'({page_q, n_q});

    // n_d_q is at most 255, so the sum stays inside the OBM window.
    assign dma_address = OBM_BASE + VRAM_ADDR_WIDTH'(n_d_q);

    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            page_q     <= 8'h00;
            n_q        <= 8'h00;
            n_d_q      <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        page_q  <= src_page;
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (vblank) begin
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Outside vblank n holds; the previous read still
                    // drains because rd_valid_q was set last cycle.
                    if (vblank) begin
                        rd_valid_q <= 1'b1;
                        n_d_q      <= n_q;
                        if (n_q == LAST_IDX) begin
                            n_q     <= 8'h00;
                            state_q <= ST_DRAIN;
                        end else begin
                            n_q <= n_q + 8'h01;
                        end
                    end
                end
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OBM_DMA_IRQ_EN
    localparam logic [VRAM_ADDR_WIDTH-1:0] CLR_ADDR =
        OBM_BASE + VRAM_ADDR_WIDTH'(DMA_IRQ_CLR_OFFSET);

    logic irq_q;

    assign swallow = cpu_write_enable && (cpu_vram_address == CLR_ADDR);
    assign irq     = irq_q;

    // Set is tested first so it wins over a coincident clear.
    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else if (state_q == ST_DRAIN) begin
            irq_q <= 1'b1;
        end else if (swallow) begin
            irq_q <= 1'b0;
        end
    end
`else
    assign swallow = 1'b0;
    assign irq     = 1'b0;
`endif

    vram_write_mux #(
        .VRAM_ADDR_WIDTH (VRAM_ADDR_WIDTH)
    ) u_mux (
        .dma_busy          (dma_busy),
        .dma_we            (rd_valid_q),
        .dma_address       (dma_address),
        .dma_data          (ram_rdata),
        .cpu_vram_address  (cpu_vram_address),
        .cpu_data          (cpu_data),
        .cpu_write_enable  (cpu_write_enable),
        .cpu_select_obm    (cpu_select_obm),
        .swallow           (swallow),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_write_enable (vram_write_enable),
        .vram_select_obm   (vram_select_obm),
        .cpu_stall         (cpu_stall)
    );

endmodule

// File: tb/tb_obm_dma_controller.sv
// Directed + randomized bench for obm_dma_controller.
// Models work RAM and the OBM write side; checks contents, order and timing.
module tb_obm_dma_controller;
    import gpu_dma_pkg::*;

    logic        gpu_clk;
    logic        rst;
    logic        start;
    logic [7:0]  src_page;
    logic [8:0]  next_y;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic        ram_rd_en;
    logic [7:0]  ram_rdata;
    logic [11:0] cpu_vram_address;
    logic [7:0]  cpu_data;
    logic        cpu_write_enable;
    logic        cpu_select_obm;
    logic [11:0] vram_address;
    logic [7:0]  vram_data;
    logic        vram_write_enable;
    logic        vram_select_obm;
    logic        cpu_stall;
    logic        irq;

    obm_dma_controller dut (
        .gpu_clk           (gpu_clk),
        .rst               (rst),
        .start             (start),
        .src_page          (src_page),
        .next_y            (next_y),
        .busy              (busy),
        .done              (done),
        .ram_addr          (ram_addr),
        .ram_rd_en         (ram_rd_en),
        .ram_rdata         (ram_rdata),
        .cpu_vram_address  (cpu_vram_address),
        .cpu_data          (cpu_data),
        .cpu_write_enable  (cpu_write_enable),
        .cpu_select_obm    (cpu_select_obm),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_write_enable (vram_write_enable),
        .vram_select_obm   (vram_select_obm),
        .cpu_stall         (cpu_stall),
        .irq               (irq)
    );

    initial gpu_clk = 1'b0;
    always #5 gpu_clk = ~gpu_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] ram [65536];
    logic [7:0] obm [OBM_BYTES];
    int         wr_q [$];
    int         rd_cnt;
    int         done_cnt;
    int         first_rd;
    int         last_wr;
    int         done_cyc;

    // Synchronous work RAM: data appears the cycle after the read strobe.
    always @(posedge gpu_clk) begin
        cyc++;
        if (ram_rd_en) ram_rdata <= ram[ram_addr];
    end

    // Foreground-side observer, sampled mid-cycle.
    always @(negedge gpu_clk) begin
        if (ram_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (vram_write_enable && vram_select_obm &&
            vram_address[11:8] == 4'h8) begin
            obm[vram_address[7:0]] = vram_data;
            wr_q.push_back(int'(vram_address[7:0]));
            last_wr = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_page(input logic [7:0] p, input bit pattern);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            ram[{p, iv}] = pattern ? (iv ^ 8'hA5) : 8'($urandom);
        end
    endtask

    task automatic begin_xfer(input logic [7:0] p);
        for (int i = 0; i < OBM_BYTES; i++) obm[i] = 8'hxx;
        wr_q.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        first_rd = -1;
        next_y   = 9'd100;
        src_page = p;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        src_page = 8'h00;
        tick();
        chk("armed_busy", busy, 1);
        chk("armed_no_read", rd_cnt, 0);
        next_y = 9'(240 + $urandom_range(0, 20));
    endtask

    task automatic wait_reads(input int n);
        int b = 0;
        while (rd_cnt < n && b < 2000) begin
            tick();
            b++;
        end
        chk("wait_reads_timeout", b >= 2000, 0);
    endtask

    task automatic wait_done();
        int b = 0;
        while (done_cnt == 0 && b < 3000) begin
            tick();
            b++;
        end
        chk("wait_done_timeout", b >= 3000, 0);
        tick();
        tick();
    endtask

    task automatic verify(input string tag, input logic [7:0] p);
        int bad = 0;
        int ord = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            if (obm[i] !== ram[{p, iv}]) bad++;
        end
        chk({tag, "_data"}, bad, 0);
        chk({tag, "_wr_count"}, wr_q.size(), 256);
        foreach (wr_q[i]) if (wr_q[i] != i) ord++;
        chk({tag, "_order"}, ord, 0);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int wcnt;
        rst              = 1'b1;
        start            = 1'b0;
        src_page         = 8'h00;
        next_y           = 9'd0;
        cpu_vram_address = 12'h000;
        cpu_data         = 8'h00;
        cpu_write_enable = 1'b0;
        cpu_select_obm   = 1'b0;
        rd_cnt           = 0;
        done_cnt         = 0;
        first_rd         = -1;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_vram_we", vram_write_enable, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b1;
        tick();

        fill_page(8'h30, 1'b1);
        fill_page(8'h45, 1'b0);
        fill_page(8'h12, 1'b0);
        fill_page(8'h31, 1'b0);
        fill_page(8'h5A, 1'b0);
        fill_page(8'h77, 1'b0);

        // Plain transfer with latency checks.
        begin_xfer(8'h30);
        wait_done();
        verify("basic", 8'h30);
        chk("basic_last_write", last_wr - first_rd, 256);
        chk("basic_done_lat", done_cyc - last_wr, 1);

`ifdef OBM_DMA_IRQ_EN
        chk("irq_set", irq, 1);
        repeat (5) tick();
        chk("irq_sticky", irq, 1);
        cpu_vram_address = 12'h900;
        cpu_write_enable = 1'b1;
        #1;
        chk("irq_clr_swallowed", vram_write_enable, 0);
        tick();
        cpu_write_enable = 1'b0;
        chk("irq_cleared", irq, 0);
`else
        chk("irq_off_after_done", irq, 0);
        cpu_vram_address = 12'h900;
        cpu_write_enable = 1'b1;
        #1;
        chk("clr_addr_passthru", vram_write_enable, 1);
        tick();
        cpu_write_enable = 1'b0;
        chk("irq_off_after_clr", irq, 0);
`endif

        // Vblank ends mid-transfer, then returns.
        begin_xfer(8'h45);
        wait_reads(100);
        next_y = 9'($urandom_range(0, 239));
        repeat (50) tick();
        chk("pause_reads_held", rd_cnt, 100);
        chk("pause_busy", busy, 1);
        next_y = 9'd250;
        wait_done();
        verify("pause", 8'h45);

        // CPU writes during XFER and a second start.
        begin_xfer(8'h12);
        wait_reads(20);
        cpu_vram_address = 12'h805;
        cpu_data         = 8'h77;
        cpu_select_obm   = 1'b1;
        cpu_write_enable = 1'b1;
        #1;
        chk("xfer_obm_stall", cpu_stall, 1);
        chk("xfer_obm_not_fwd", vram_address == 12'h805, 0);
        tick();
        cpu_vram_address = 12'h123;
        cpu_select_obm   = 1'b0;
        #1;
        chk("xfer_other_stall", cpu_stall, 1);
        tick();
        cpu_write_enable = 1'b0;
        wait_reads(60);
        src_page = 8'h31;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        src_page = 8'h00;
        wait_done();
        verify("restart_ignored", 8'h12);

        // The same CPU write while idle lands.
        cpu_vram_address = 12'h805;
        cpu_data         = 8'h77;
        cpu_select_obm   = 1'b1;
        cpu_write_enable = 1'b1;
        #1;
        chk("idle_no_stall", cpu_stall, 0);
        chk("idle_fwd_addr", vram_address, 12'h805);
        tick();
        cpu_write_enable = 1'b0;
        cpu_select_obm   = 1'b0;
        tick();
        chk("idle_write_landed", obm[5], 8'h77);

        // Reset in the middle of a transfer.
        begin_xfer(8'h5A);
        wait_reads(40);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", ram_rd_en, 0);
        chk("midrst_vram_we", vram_write_enable, 0);
        chk("midrst_done", done, 0);
        wcnt = wr_q.size();
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("midrst_no_writes", wr_q.size(), wcnt);
        chk("midrst_still_idle", busy, 0);
        chk("midrst_no_done", done_cnt, 0);

        begin_xfer(8'h77);
        wait_done();
        verify("after_rst", 8'h77);
        chk("after_rst_last_write", last_wr - first_rd, 256);
`ifndef OBM_DMA_IRQ_EN
        chk("irq_off_end", irq, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
